axil_regfile: RTL and testbench
===============================

# axil_regfile

Parametrised AXI4-Lite slave register file: the next-generation control/status register block that sits between an AXI4-Lite interconnect port and a peripheral's configuration/status fabric. Generalises data width and register count and accepts AW and W in any order. Adds hardware-driven read-only registers and SLVERR responses for out-of-range or read-only writes. One outstanding write and one outstanding read; each channel has its own FSM.

## Interface
- DW, 32, data width; 32 or 64 only
- AW, 12, byte-address width; must be ≥ $clog2(REG_NUM)+$clog2(DW/8)
- REG_NUM, 16, number of registers; ≥ 2
- RO_MASK, '0, REG_NUM bits; bit i=1 makes register i read-only, sourced from status_i[i]
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- awvalid/awready  in/out  1  write-address handshake
- awaddr  in  AW  write byte address
- wvalid/wready  in/out  1  write-data handshake
- wdata  in  DW  write data
- wstrb  in  DW/8  byte enables
- bvalid/bready  out/in  1  write-response handshake
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid/arready  in/out  1  read-address handshake
- araddr  in  AW  read byte address
- rvalid/rready  out/in  1  read-data handshake
- rdata  out  DW  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- regs_o  out  REG_NUM×DW  current RW register contents; RO entries drive 0
- status_i  in  REG_NUM×DW  hardware status for RO registers; RW entries ignored

## Operation
- Word index = addr[AW-1:$clog2(DW/8)]; low byte-offset bits ignored.
- Write FSM W_IDLE → W_RESP → W_IDLE. In W_IDLE, awready = !aw_got and wready = !w_got. AW and W are latched independently, in any order or in the same cycle.
- When aw_got && w_got in W_IDLE: commit the write, set bvalid, clear both flags, enter W_RESP. In W_RESP, awready = wready = 0.
- Commit: if index < REG_NUM and RO_MASK[index]=0, update each byte lane where wstrb=1 and return bresp=OKAY. Otherwise no state change and bresp=SLVERR.
- W_RESP → W_IDLE on bvalid && bready. bvalid and bresp hold stable until then.
- Read FSM R_IDLE → R_RESP → R_IDLE. arready = 1 only in R_IDLE.
- On AR handshake: load rdata and rresp, set rvalid, enter R_RESP.
  - In range, RW register: rdata = register value, rresp = OKAY.
  - In range, RO register: rdata = status_i sampled at that edge, rresp = OKAY.
  - Out of range: rdata = 0, rresp = SLVERR.
- R_RESP → R_IDLE on rvalid && rready. rdata and rresp stay stable throughout R_RESP.
- Read and write FSMs run independently. If a read handshake and a write commit hit the same register at the same edge, the read returns the pre-write value.

## Timing
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=00, rdata=0, regs_o=0, all FSMs idle, all flags clear.
- Write latency: the register updates and bvalid rises at the edge after the later of the AW/W handshakes. With simultaneous AW+W at edge N, bvalid is high after edge N+1.
- Read latency: rvalid is high in the cycle after the AR handshake edge.
- Peak throughput: one write per 3 cycles with bready tied high; one read per 2 cycles with rready tied high.
- Reset asserted mid-transaction: latched addresses, data and pending responses are dropped and registers clear. No B or R beat is issued for the aborted transaction.
- Elaboration-time assertions check DW ∈ {32,64}, REG_NUM ≥ 2, the AW bound, and $bits(RO_MASK) == REG_NUM.

## Configuration
- AXIL_REGFILE_WPULSE_EN defined: adds output wr_pulse (REG_NUM bits). Bit i is high for exactly one cycle, the cycle after a successful OKAY commit to register i. SLVERR writes produce no pulse.
- Not defined: the wr_pulse port and its logic are absent. All other behaviour is identical.

## Structure
- Package axil_pkg holds:
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10)
  - wstate_t {W_IDLE, W_RESP} and rstate_t {R_IDLE, R_RESP}
  - the index-width localparam function
- One sub-module, axil_wjoin, owns the AW/W collection, the write FSM and B-channel generation. It outputs a one-cycle commit strobe with index/data/strb to the register array in the top level.

## Test plan
- AW at cycle 0, W at cycle 3 (addr 0x08, data 0xDEADBEEF, strb 0xF) → bvalid at cycle 4, bresp=00, regs_o[2]=0xDEADBEEF. Repeat with W first, then AW: same result.
- Write 0xFFFFFFFF, then 0x00000000 with strb 0x5 to reg 1 → reg 1 reads 0xFF00FF00 with rresp=00.
- Write to index REG_NUM (addr 0x40 for default parameters) → bresp=10, no register changes; read the same address → rdata=0, rresp=10.
- RO_MASK bit 3 set, status_i[3]=0x12345678 → read addr 0x0C returns 0x12345678; write there → bresp=10, status unaffected.
- Hold bready and rready low for 5 cycles → bvalid/rvalid and data stay stable; awready, wready and arready stay 0 until the respective handshake.
- Assert reset while bvalid is pending → next cycle bvalid=0, regs_o all zero, awready=1. With AXIL_REGFILE_WPULSE_EN defined, a write to reg 2 gives wr_pulse=0x0004 for exactly one cycle.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: response/state types and index-width helper shared by the axil_regfile slice
package axil_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axil_regfile_if.sv
// axil_regfile_if: AXI4-Lite bus between an interconnect master and the register file slave
interface axil_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_wjoin.sv
// axil_wjoin: joins AW and W in any order, runs the write FSM and B channel, strobes accepted commits
module axil_wjoin import axil_pkg::*; #(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int REG_NUM = 16,
  parameter logic [REG_NUM-1:0] RO_MASK = '0,
  localparam int LSB = $clog2(DW/8),
  localparam int WI = AW - LSB,
  localparam int IW = idx_bits(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  axil_regfile_if.slave   bus,
  output logic            we,
  output logic [IW-1:0]   widx,
  output logic [DW-1:0]   wdat,
  output logic [DW/8-1:0] wstb
);
  wstate_t st;
  logic aw_got, w_got, hit, ok;
  logic [WI-1:0] word;
  assign hit = st == W_IDLE && aw_got && w_got;
  assign widx = word[IW-1:0];
  assign ok = ({1'b0, word} < (WI+1)'(REG_NUM)) && !RO_MASK[widx];
  assign we = hit && ok;
  assign bus.awready = st == W_IDLE && !aw_got;
  assign bus.wready = st == W_IDLE && !w_got;
  // Both flags are set only while their ready is low, so commit and latch never collide
  always_ff @(posedge clk)
    if (rst) begin
      st <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      word <= '0;
      wdat <= '0;
      wstb <= '0;
      bus.bvalid <= 1'b0;
      bus.bresp <= OKAY;
    end else if (st == W_IDLE) begin
      if (hit) begin
        st <= W_RESP;
        aw_got <= 1'b0;
        w_got <= 1'b0;
        bus.bvalid <= 1'b1;
        bus.bresp <= ok ? OKAY : SLVERR;
      end
      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1;
        word <= bus.awaddr[AW-1:LSB];
      end
      if (bus.wvalid && bus.wready) begin
        w_got <= 1'b1;
        wdat <= bus.wdata;
        wstb <= bus.wstrb;
      end
    end else if (bus.bready) begin
      st <= W_IDLE;
      bus.bvalid <= 1'b0;
    end
endmodule

// File: rtl/axil_regfile.sv
// axil_regfile: AXI4-Lite register file with byte-strobed RW registers and hardware-sourced RO registers.
// Define AXIL_REGFILE_WPULSE_EN to add the per-register wr_pulse output.
module axil_regfile import axil_pkg::*; #(
  parameter int DW = 32,
  parameter int AW = 12,
  parameter int REG_NUM = 16,
  parameter logic [REG_NUM-1:0] RO_MASK = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  axil_regfile_if.slave                bus,
  output logic [REG_NUM-1:0][DW-1:0]   regs_o,
  input  logic [REG_NUM-1:0][DW-1:0]   status_i
`ifdef AXIL_REGFILE_WPULSE_EN
  ,
  output logic [REG_NUM-1:0]           wr_pulse
`endif
);
  localparam int LSB = $clog2(DW/8);
  localparam int WI = AW - LSB;
  localparam int IW = idx_bits(REG_NUM);
  if (DW != 32 && DW != 64) begin : g_dw_chk
    $error("axil_regfile: DW must be 32 or 64");
  end
  if (REG_NUM < 2) begin : g_num_chk
    $error("axil_regfile: REG_NUM must be at least 2");
  end
  if (AW < $clog2(REG_NUM) + LSB) begin : g_aw_chk
    $error("axil_regfile: AW too small to address REG_NUM registers");
  end
  if ($bits(RO_MASK) != REG_NUM) begin : g_mask_chk
    $error("axil_regfile: RO_MASK width must equal REG_NUM");
  end
  logic [REG_NUM-1:0][DW-1:0] regs;
  logic we, rin, unused;
  logic [IW-1:0] widx, ridx;
  logic [DW-1:0] wdat;
  logic [DW/8-1:0] wstb;
  logic [WI-1:0] rword;
  rstate_t rs;
  axil_wjoin #(.DW(DW), .AW(AW), .REG_NUM(REG_NUM), .RO_MASK(RO_MASK)) u_wjoin (
    .clk(clk), .rst(reset), .bus(bus), .we(we), .widx(widx), .wdat(wdat), .wstb(wstb)
  );
  always_ff @(posedge clk)
    if (reset) regs <= '0;
    else if (we)
      for (int b = 0; b < DW/8; b++)
        if (wstb[b]) regs[widx][8*b +: 8] <= wdat[8*b +: 8];
  always_comb
    for (int i = 0; i < REG_NUM; i++) regs_o[i] = RO_MASK[i] ? '0 : regs[i];
  assign rword = bus.araddr[AW-1:LSB];
  assign ridx = rword[IW-1:0];
  assign rin = {1'b0, rword} < (WI+1)'(REG_NUM);
  assign bus.arready = rs == R_IDLE;
  assign unused = ^{bus.araddr[LSB-1:0], bus.awaddr[LSB-1:0]};
  // regs is sampled before any same-edge commit lands, giving read-before-write ordering
  always_ff @(posedge clk)
    if (reset) begin
      rs <= R_IDLE;
      bus.rvalid <= 1'b0;
      bus.rdata <= '0;
      bus.rresp <= OKAY;
    end else if (rs == R_IDLE) begin
      if (bus.arvalid) begin
        rs <= R_RESP;
        bus.rvalid <= 1'b1;
        bus.rresp <= rin ? OKAY : SLVERR;
        bus.rdata <= !rin ? '0 : RO_MASK[ridx] ? status_i[ridx] : regs[ridx];
      end
    end else if (bus.rready) begin
      rs <= R_IDLE;
      bus.rvalid <= 1'b0;
    end
`ifdef AXIL_REGFILE_WPULSE_EN
  always_ff @(posedge clk)
    if (reset) wr_pulse <= '0;
    else wr_pulse <= we ? (REG_NUM'(1) << widx) : '0;
`endif
endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: randomized self-checking bench for axil_regfile against an array-based register model
module tb_axil_regfile;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int N = 16;
  localparam logic [N-1:0] RO = 16'h0008;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0][DW-1:0] regs, status;
  logic [31:0] mdl [N];
  int checks = 0;
  int errors = 0;
`ifdef AXIL_REGFILE_WPULSE_EN
  logic [N-1:0] wr_pulse;
`endif
  axil_regfile_if #(.DW(DW), .AW(AW)) bus();
  axil_regfile #(.DW(DW), .AW(AW), .REG_NUM(N), .RO_MASK(RO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .regs_o(regs), .status_i(status)
`ifdef AXIL_REGFILE_WPULSE_EN
    , .wr_pulse(wr_pulse)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    logic [31:0] m;
    i = int'(a) / 4;
    m = 32'h0;
    if (i >= N || RO[i]) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    mdl[i] = (mdl[i] & ~m) | (d & m);
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [AW-1:0] a);
    int i;
    i = int'(a) / 4;
    if (i >= N) return {2'b10, 32'h0};
    return {2'b00, RO[i] ? status[i] : mdl[i]};
  endfunction

  function automatic logic [N-1:0][DW-1:0] model_regs();
    logic [N-1:0][DW-1:0] r;
    for (int i = 0; i < N; i++) r[i] = RO[i] ? 32'h0 : mdl[i];
    return r;
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ad, input int wd, output logic [1:0] resp);
    bus.bready = 1'b0;
    fork
      begin
        repeat (ad) @(negedge clk);
        bus.awaddr = a;
        bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.awready; i++) @(negedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
      end
      begin
        repeat (wd) @(negedge clk);
        bus.wdata = d;
        bus.wstrb = s;
        bus.wvalid = 1'b1;
        for (int i = 0; i < 50 && !bus.wready; i++) @(negedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
      end
    join
    resp = 2'bxx;
    bus.bready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.bvalid) begin
        resp = bus.bresp;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, output logic [31:0] d, output logic [1:0] resp);
    repeat (dly) @(negedge clk);
    bus.araddr = a;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 50 && !bus.arready; i++) @(negedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    d = 32'hx;
    resp = 2'bxx;
    bus.rready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.rvalid) begin
        d = bus.rdata;
        resp = bus.rresp;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} = '0;
    bus.awaddr = '0;
    bus.araddr = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    for (int i = 0; i < N; i++) status[i] = $urandom;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 9'b111_00_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp %b", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 9'b111_00_0000);
    end
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h exp 0", bus.rdata);
    end
    checks++;
    if (regs !== '0) begin
      errors++;
      $display("FAIL reset_regs: got %h exp 0", regs);
    end
    reset = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_order();
    logic [31:0] d;
    logic [1:0] r;
    for (int v = 0; v < 2; v++) begin
      d = v ? 32'h0BAD_F00D : 32'hDEAD_BEEF;
      r = model_write(12'h008, d, 4'hF);
      bus.bready = 1'b0;
      for (int c = 0; c < 6; c++) begin
        bus.awvalid = v ? (c == 3) : (c == 0);
        bus.awaddr = 12'h008;
        bus.wvalid = v ? (c == 0) : (c == 3);
        bus.wdata = d;
        bus.wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if ({bus.bvalid, bus.awready, bus.wready} !== {c >= 4, v == 1 && c < 3, v == 0 && c < 3}) begin
          errors++;
          $display("FAIL order%0d_c%0d bvalid/awready/wready: got %b exp %b", v, c,
                   {bus.bvalid, bus.awready, bus.wready}, {c >= 4, v == 1 && c < 3, v == 0 && c < 3});
        end
      end
      checks++;
      if (bus.bresp !== r || regs[2] !== 32'hDEAD_BEEF + 32'(v) * (32'h0BAD_F00D - 32'hDEAD_BEEF)) begin
        errors++;
        $display("FAIL order%0d bresp/reg2: got %b %h exp %b %h", v, bus.bresp, regs[2], r, mdl[2]);
      end
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      checks++;
      if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
        errors++;
        $display("FAIL order%0d after_b: got %b exp 011", v, {bus.bvalid, bus.awready, bus.wready});
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    logic [31:0] d;
    do_write(12'h004, 32'hFFFF_FFFF, 4'hF, 1, 0, r);
    do_write(12'h004, 32'h0000_0000, 4'h5, 0, 2, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("FAIL strobe bresp: got %b exp 00", r);
    end
    do_read(12'h004, 0, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'hFF00_FF00}) begin
      errors++;
      $display("FAIL strobe read: got %b %h exp 00 ff00ff00", r, d);
    end
    r = model_write(12'h004, 32'hFFFF_FFFF, 4'hF);
    r = model_write(12'h004, 32'h0, 4'h5);
  endtask

  task automatic test_range();
    logic [1:0] r;
    logic [31:0] d;
    do_write(12'h040, 32'h1234_5678, 4'hF, 0, 1, r);
    checks++;
    if (r !== 2'b10 || regs !== model_regs()) begin
      errors++;
      $display("FAIL range write: got %b exp 10 (regs match %0d)", r, regs === model_regs());
    end
    do_read(12'h040, 1, d, r);
    checks++;
    if ({r, d} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL range read: got %b %h exp 10 0", r, d);
    end
    do_read(12'hFFC, 0, d, r);
    checks++;
    if ({r, d} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL range read_top: got %b %h exp 10 0", r, d);
    end
  endtask

  task automatic test_ro();
    logic [1:0] r;
    logic [31:0] d;
    status[3] = 32'h1234_5678;
    do_read(12'h00C, 0, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h1234_5678}) begin
      errors++;
      $display("FAIL ro read: got %b %h exp 00 12345678", r, d);
    end
    do_write(12'h00C, 32'hAAAA_5555, 4'hF, 2, 0, r);
    checks++;
    if (r !== 2'b10 || regs[3] !== 32'h0) begin
      errors++;
      $display("FAIL ro write: got %b %h exp 10 0", r, regs[3]);
    end
    do_read(12'h00C, 0, d, r);
    checks++;
    if ({r, d} !== {2'b00, 32'h1234_5678}) begin
      errors++;
      $display("FAIL ro reread: got %b %h exp 00 12345678", r, d);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    a = $urandom;
    bus.awaddr = 12'h040;
    bus.wdata = a;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b1_10_00) begin
        errors++;
        $display("FAIL stall_b%0d: got %b exp 11000", k, {bus.bvalid, bus.bresp, bus.awready, bus.wready});
      end
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    status[3] = a;
    bus.araddr = 12'h00C;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    status[3] = ~a;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.rvalid, bus.rresp, bus.arready, bus.rdata} !== {1'b1, 2'b00, 1'b0, a}) begin
        errors++;
        $display("FAIL stall_r%0d: got %b %b %b %h exp 1 00 0 %h", k, bus.rvalid, bus.rresp, bus.arready, bus.rdata, a);
      end
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0011) begin
      errors++;
      $display("FAIL stall_done: got %b exp 0011", {bus.bvalid, bus.rvalid, bus.awready, bus.arready});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old, d;
    logic [1:0] r;
    old = mdl[6];
    d = ~old ^ $urandom;
    r = model_write(12'h018, d, 4'hF);
    bus.awaddr = 12'h018;
    bus.wdata = d;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.araddr = 12'h018;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    checks++;
    if ({bus.rvalid, bus.rdata, bus.bvalid, bus.bresp, regs[6]} !== {1'b1, old, 1'b1, r, d}) begin
      errors++;
      $display("FAIL raw: got rv=%b rd=%h bv=%b br=%b reg6=%h exp 1 %h 1 %b %h",
               bus.rvalid, bus.rdata, bus.bvalid, bus.bresp, regs[6], old, r, d);
    end
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic [1:0] r, er;
    logic [33:0] exp_rd;
    for (int n = 0; n < 150; n++) begin
      status[3] = $urandom;
      status[0] = $urandom;
      a = ($urandom_range(0, 5) == 0) ? AW'($urandom) : AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        er = model_write(a, d, s);
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
        checks++;
        if (r !== er) begin
          errors++;
          $display("FAIL rand_write%0d addr %h: got %b exp %b", n, a, r, er);
        end
      end else begin
        exp_rd = model_read(a);
        do_read(a, $urandom_range(0, 2), d, r);
        checks++;
        if ({r, d} !== exp_rd) begin
          errors++;
          $display("FAIL rand_read%0d addr %h: got %b %h exp %b %h", n, a, r, d, exp_rd[33:32], exp_rd[31:0]);
        end
      end
      checks++;
      if (regs !== model_regs()) begin
        errors++;
        $display("FAIL rand_regs%0d: got %h exp %h", n, regs, model_regs());
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.awaddr = 12'h010;
    bus.wdata = 32'hC0FF_EE11;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.araddr = 12'h010;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    checks++;
    if ({bus.bvalid, bus.rvalid, regs[4]} !== {2'b11, 32'hC0FF_EE11}) begin
      errors++;
      $display("FAIL midrst_pre: got %b %b %h exp 1 1 c0ffee11", bus.bvalid, bus.rvalid, regs[4]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = 32'h0;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111 || regs !== '0) begin
      errors++;
      $display("FAIL midrst: got %b regs %h exp 00111 regs 0",
               {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, regs);
    end
    seen = 0;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.bvalid || bus.rvalid) seen++;
    end
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_beat: got %0d stray beats exp 0", seen);
    end
  endtask

`ifdef AXIL_REGFILE_WPULSE_EN
  task automatic test_wpulse();
    int hits, bad;
    logic [1:0] r, er;
    for (int v = 0; v < 2; v++) begin
      hits = 0;
      bad = 0;
      er = model_write(v ? 12'h00C : 12'h008, 32'h1111_2222, 4'hF);
      fork
        do_write(v ? 12'h00C : 12'h008, 32'h1111_2222, 4'hF, 0, 0, r);
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (wr_pulse === 16'h0004) hits++;
          else if (wr_pulse !== 16'h0) bad++;
        end
      join
      checks++;
      if (r !== er || hits !== (v ? 0 : 1) || bad !== 0) begin
        errors++;
        $display("FAIL wpulse%0d: got resp %b hits %0d other %0d exp %b %0d 0", v, r, hits, bad, er, v ? 0 : 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_order();
    test_strobe();
    test_range();
    test_ro();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef AXIL_REGFILE_WPULSE_EN
    test_wpulse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
